struct_field_updater: RTL and testbench

Sequential update stage feeding the escaped-identifier struct test module. It holds a two-field record: field A is the flat int member, and field B is the `ld` member of the nested `fie_t` struct. It accepts field-update commands over a valid/ready interface and buffers them in a small FIFO. It retires one command per cycle and presents both fields continuously as `o1`/`o2`, which the downstream assign/initial consumers read.

---
 rtl/struct_field_updater.sv | 131 +++++++++++++
 tb/tb_struct_field_updater.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/struct_field_updater.sv
// struct_field_updater
//   Holds a two-field record (A = flat int member, B = nested fie_t.ld) and
//   applies field-update commands taken from a small in-order FIFO, one
//   command retired per cycle whenever the FIFO is non-empty.
//
// Ports
//   clk, rst_n         clock (rising edge), async active-low reset
//   req_valid/ready    command handshake; ready = !full
//   req_op             0 WRITE, 1 ADD, 2 COPY, 3 SWAP
//   req_sel            target field: 0 = A, 1 = B
//   req_data           signed 32-bit operand
//   o1, o2             field A / field B registers
//   upd_valid          pulse in the cycle after a command retires
//   upd_count          16-bit wrapping retire counter
//   busy               FIFO non-empty
module struct_field_updater #(
  parameter int                 DEPTH   = 4,
  parameter logic signed [31:0] RESET_A = 32'sd1111,
  parameter logic signed [31:0] RESET_B = 32'sd2222
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_sel,
  input  logic [31:0] req_data,
  output logic [31:0] o1,
  output logic [31:0] o2,
  output logic        upd_valid,
  output logic [15:0] upd_count,
  output logic        busy
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_ADD   = 2'd1,
    OP_COPY  = 2'd2,
    OP_SWAP  = 2'd3
  } op_e;

  typedef struct packed {
    op_e         op;
    logic        sel;
    logic [31:0] data;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          upd_valid_q;
  logic [15:0]   upd_count_q;

  logic full, empty, push, pop;
  cmd_t head;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  // ready depends on the registered count only, so a same-cycle pop never
  // frees a slot while full
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = !empty;
  assign head      = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset: emptiness is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= cmd_t'{op_e'(req_op), req_sel, req_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Execute head; COPY/SWAP read the pre-edge values so SWAP is atomic.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (pop) begin
      case (head.op)
        OP_WRITE: if (head.sel) b_d = head.data;        else a_d = head.data;
        OP_ADD:   if (head.sel) b_d = b_q + head.data;  else a_d = a_q + head.data;
        OP_COPY:  if (head.sel) b_d = a_q;              else a_d = b_q;
        OP_SWAP:  begin a_d = b_q; b_d = a_q; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= RESET_A;
      b_q         <= RESET_B;
      upd_valid_q <= 1'b0;
      upd_count_q <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      upd_valid_q <= pop;
      upd_count_q <= upd_count_q + {15'd0, pop};
    end
  end

  assign o1        = a_q;
  assign o2        = b_q;
  assign upd_valid = upd_valid_q;
  assign upd_count = upd_count_q;
  assign busy      = !empty;

endmodule

// File: tb/tb_struct_field_updater.sv
module tb_struct_field_updater;

  localparam int DEPTH = 4;
  localparam int RA    = 1111;
  localparam int RB    = 2222;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic        req_sel = 1'b0;
  logic [31:0] req_data = 32'd0;
  logic [31:0] o1, o2;
  logic        upd_valid;
  logic [15:0] upd_count;
  logic        busy;

  struct_field_updater #(.DEPTH(DEPTH), .RESET_A(RA), .RESET_B(RB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sel(req_sel), .req_data(req_data),
    .o1(o1), .o2(o2), .upd_valid(upd_valid), .upd_count(upd_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending commands plus the two field values.
  typedef struct { int op; int sel; int data; } mcmd_t;
  mcmd_t mq[$];
  int    m_a, m_b, m_cnt;
  bit    m_uv;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_a = RA; m_b = RB; m_cnt = 0; m_uv = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".o1"},   o1,                 m_a);
    chk({tag, ".o2"},   o2,                 m_b);
    chk({tag, ".uv"},   {31'd0, upd_valid}, {31'd0, m_uv});
    chk({tag, ".cnt"},  {16'd0, upd_count}, m_cnt & 32'hFFFF);
    chk({tag, ".busy"}, {31'd0, busy},      {31'd0, mq.size() != 0});
  endtask

  // One cycle: called at a negedge, drives inputs, crosses the posedge,
  // advances the model, and compares at the following negedge.
  task automatic step(input string tag, input bit v, input int op, input bit sel, input int data);
    bit    exp_rdy, popped;
    mcmd_t c;
    req_valid = v; req_op = op[1:0]; req_sel = sel; req_data = data;
    exp_rdy = (mq.size() < DEPTH);
    #1 chk({tag, ".rdy"}, {31'd0, req_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    popped = (mq.size() != 0);
    if (popped) begin
      c = mq.pop_front();
      case (c.op)
        0: if (c.sel) m_b = c.data; else m_a = c.data;
        1: if (c.sel) m_b = m_b + c.data; else m_a = m_a + c.data;
        2: if (c.sel) m_b = m_a; else m_a = m_b;
        default: begin int t; t = m_a; m_a = m_b; m_b = t; end
      endcase
      m_cnt++;
    end
    m_uv = popped;
    if (v && exp_rdy) mq.push_back('{op, sel, data});
    @(negedge clk);
    req_valid = 1'b0;
    check_outs(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs("reset");
    chk("reset.rdy", {31'd0, req_ready}, 32'd1);

    // WRITE A then B back-to-back
    step("wr_a", 1, 0, 0, 3333);
    step("wr_b", 1, 0, 1, 9999);
    step("wr_1", 0, 0, 0, 0);
    step("wr_2", 0, 0, 0, 0);

    // ADD wrap around the signed boundary
    step("add_w", 1, 0, 0, 32'h7FFFFFFF);
    step("add_p", 1, 1, 0, 1);
    step("add_m", 1, 1, 0, -1);
    step("add_i", 0, 0, 0, 0);
    step("add_j", 0, 0, 0, 0);

    // COPY / SWAP starting from reset values
    rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1;
    step("cp_b",  1, 2, 1, 12345);
    step("wr_a5", 1, 0, 0, 5);
    step("swap",  1, 3, 1, 777);
    step("cs_i",  0, 0, 0, 0);
    step("cs_j",  0, 0, 0, 0);

    // Burst of 6 distinct WRITEs to A with valid held high
    for (int i = 0; i < 6; i++) step($sformatf("burst%0d", i), 1, 0, 0, 100 + i * 7);
    step("burst_i", 0, 0, 0, 0);
    step("burst_j", 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 200; i++)
      step($sformatf("rnd%0d", i), bit'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), int'($urandom));

    // Reset mid-operation with commands in flight
    step("mr0", 1, 0, 0, 42);
    step("mr1", 1, 1, 1, 9);
    step("mr2", 1, 3, 0, 0);
    req_valid = 1'b1; req_op = 2'd0; req_sel = 1'b0; req_data = 32'd55;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outs("mrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_outs("mrst_hold");
    rst_n = 1'b1;
    step("post0", 0, 0, 0, 0);
    step("post1", 0, 0, 0, 0);
    step("post2", 1, 1, 1, 1);
    step("post3", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
